// File: rtl/nonogram_pkg.sv
// Shared types and helpers for the nonogram line-option generator and the solver.
package nonogram_pkg;

  localparam int MAX_LEN   = 32;
  localparam int MAX_CLUES = 16;
  localparam int WORD_W    = 13;
  localparam int CELL_W    = 12;

  localparam int LEN_W = $clog2(MAX_LEN + 1);    // cell count / clue value
  localparam int K_W   = $clog2(MAX_CLUES + 1);  // clue count
  localparam int CI_W  = $clog2(MAX_CLUES);      // clue register-file index
  localparam int SUM_W = LEN_W + CI_W;           // sum of all clues

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_PACK,
    S_BUILD,
    S_EMIT_HDR,
    S_EMIT_CELLS,
    S_ADVANCE,
    S_REPACK,
    S_DONE
  } state_t;

  // Line parameters captured on an accepted start.
  typedef struct packed {
    logic [CELL_W-1:0] id;
    logic [LEN_W-1:0]  len;
    logic [CELL_W-1:0] base;
    logic [CELL_W-1:0] stride;
  } line_cfg_t;

  function automatic logic [WORD_W-1:0] mk_header(input logic [CELL_W-1:0] id);
    return {1'b0, id};
  endfunction

  function automatic logic [WORD_W-1:0] mk_cell(input logic v, input logic [CELL_W-1:0] idx);
    return {v, idx};
  endfunction

endpackage

// File: rtl/line_option_gen_if.sv
// Clue input stream and option-word output stream of line_option_gen.
interface line_option_gen_if;
  import nonogram_pkg::*;

  logic              clue_valid;
  logic              clue_ready;
  logic [LEN_W-1:0]  clue;
  logic              clue_last;
  logic [WORD_W-1:0] out_word;
  logic              out_valid;
  logic              out_ready;

  // Feeder / consumer side.
  modport master (
    output clue_valid, clue, clue_last, out_ready,
    input  clue_ready, out_word, out_valid
  );

  // Generator side.
  modport slave (
    input  clue_valid, clue, clue_last, out_ready,
    output clue_ready, out_word, out_valid
  );

endinterface

// File: rtl/line_option_gen.sv
// Enumerates every legal clue placement for one nonogram line and streams each
// as a header word followed by one {value, cell_index} word per cell.
module line_option_gen
  import nonogram_pkg::*;
(
  input  logic                clk_100mhz,
  input  logic                rst,
  input  logic                start,
  input  logic [CELL_W-1:0]   line_id,
  input  logic [LEN_W-1:0]    line_len,
  input  logic [CELL_W-1:0]   base,
  input  logic [CELL_W-1:0]   stride,
  line_option_gen_if.slave    bus,
  output logic                busy,
  output logic                done,
  output logic                infeasible,
  output logic [15:0]         option_count
);

  state_t            state;
  line_cfg_t         cfg;
  logic [LEN_W-1:0]  clue_mem  [MAX_CLUES];
  logic [LEN_W-1:0]  start_mem [MAX_CLUES];
  logic [K_W-1:0]    k_cnt;      // number of nonzero clues kept
  logic [K_W-1:0]    cnt;        // per-state clue index
  logic [SUM_W-1:0]  sum_q;
  logic              ovf;
  logic [MAX_LEN-1:0] bitmap;
  logic [MAX_LEN-1:0] cell_sr;   // bitmap shifted so bit 0 is the next cell
  logic [LEN_W-1:0]  c;
  logic [CELL_W-1:0] idx;

  logic [CI_W-1:0]   ci, ci_prv, ci_nxt;
  logic              at_last;
  logic [LEN_W-1:0]  chain_pos;
  logic [LEN_W:0]    blk_end;
  logic              movable;
  logic              too_long;
  logic [MAX_LEN-1:0] blk_mask;

  assign ci     = cnt[CI_W-1:0];
  assign ci_prv = ci - CI_W'(1);
  assign ci_nxt = ci + CI_W'(1);
  assign at_last = (cnt == k_cnt - K_W'(1));

  // Leftmost start of block ci given the previous block.
  assign chain_pos = start_mem[ci_prv] + clue_mem[ci_prv] + LEN_W'(1);

  // Block ci can slide right by one without hitting the line end or its successor.
  assign blk_end = (LEN_W+1)'(start_mem[ci]) + (LEN_W+1)'(clue_mem[ci]);
  assign movable = at_last ? (blk_end < (LEN_W+1)'(cfg.len))
                           : (blk_end + (LEN_W+1)'(1) < (LEN_W+1)'(start_mem[ci_nxt]));

  // sum + K - 1 > len, rearranged to avoid underflow.
  assign too_long = ((SUM_W+1)'(sum_q) + (SUM_W+1)'(k_cnt)) > ((SUM_W+1)'(cfg.len) + (SUM_W+1)'(1));

  // Filled cells of block ci; a full-width shift yields zero so width MAX_LEN works.
  assign blk_mask = (~({MAX_LEN{1'b1}} << clue_mem[ci])) << start_mem[ci];

  // Main control FSM with registered outputs.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state          <= S_IDLE;
      cfg            <= '0;
      k_cnt          <= '0;
      cnt            <= '0;
      sum_q          <= '0;
      ovf            <= 1'b0;
      bitmap         <= '0;
      cell_sr        <= '0;
      c              <= '0;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      infeasible     <= 1'b0;
      option_count   <= '0;
      bus.clue_ready <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_word   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cfg            <= '{id: line_id, len: line_len, base: base, stride: stride};
            k_cnt          <= '0;
            sum_q          <= '0;
            ovf            <= 1'b0;
            option_count   <= '0;
            infeasible     <= 1'b0;
            busy           <= 1'b1;
            bus.clue_ready <= 1'b1;
            state          <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (bus.clue_valid && bus.clue_ready) begin
            if (bus.clue != '0) begin
              if (k_cnt == K_W'(MAX_CLUES)) begin
                ovf <= 1'b1;
              end else begin
                clue_mem[k_cnt[CI_W-1:0]] <= bus.clue;
                k_cnt <= k_cnt + K_W'(1);
                sum_q <= sum_q + SUM_W'(bus.clue);
              end
            end
            if (bus.clue_last) begin
              bus.clue_ready <= 1'b0;
              state          <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          bitmap <= '0;
          cnt    <= '0;
          if (ovf || (k_cnt != '0 && too_long)) begin
            infeasible <= 1'b1;
            done       <= 1'b1;
            state      <= S_DONE;
          end else if (k_cnt == '0) begin
            bus.out_valid <= 1'b1;
            bus.out_word  <= mk_header(cfg.id);
            state         <= S_EMIT_HDR;
          end else begin
            state <= S_PACK;
          end
        end

        S_PACK: begin
          start_mem[ci] <= (cnt == '0) ? '0 : chain_pos;
          if (at_last) begin
            cnt   <= '0;
            state <= S_BUILD;
          end else begin
            cnt <= cnt + K_W'(1);
          end
        end

        S_BUILD: begin
          bitmap <= bitmap | blk_mask;
          if (at_last) begin
            bus.out_valid <= 1'b1;
            bus.out_word  <= mk_header(cfg.id);
            state         <= S_EMIT_HDR;
          end else begin
            cnt <= cnt + K_W'(1);
          end
        end

        S_EMIT_HDR: begin
          if (bus.out_ready) begin
            c            <= '0;
            idx          <= cfg.base;
            bus.out_word <= mk_cell(bitmap[0], cfg.base);
            cell_sr      <= bitmap >> 1;
            state        <= S_EMIT_CELLS;
          end
        end

        S_EMIT_CELLS: begin
          if (bus.out_ready) begin
            if (c == cfg.len - LEN_W'(1)) begin
              bus.out_valid <= 1'b0;
              if (option_count != 16'hFFFF) option_count <= option_count + 16'd1;
              cnt   <= k_cnt - K_W'(1);
              state <= S_ADVANCE;
            end else begin
              c            <= c + LEN_W'(1);
              idx          <= idx + cfg.stride;
              bus.out_word <= mk_cell(cell_sr[0], idx + cfg.stride);
              cell_sr      <= cell_sr >> 1;
            end
          end
        end

        S_ADVANCE: begin
          if (k_cnt == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (movable) begin
            start_mem[ci] <= start_mem[ci] + LEN_W'(1);
            bitmap        <= '0;
            if (at_last) begin
              cnt   <= '0;
              state <= S_BUILD;
            end else begin
              cnt   <= cnt + K_W'(1);
              state <= S_REPACK;
            end
          end else if (cnt == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt - K_W'(1);
          end
        end

        S_REPACK: begin
          start_mem[ci] <= chain_pos;
          if (at_last) begin
            cnt   <= '0;
            state <= S_BUILD;
          end else begin
            cnt <= cnt + K_W'(1);
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_option_gen.sv
// Directed bench for line_option_gen: expected words are queued by the stimulus
// and a negedge monitor pops and compares every transferred word.
module tb_line_option_gen;
  import nonogram_pkg::*;

  logic              clk_100mhz = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CELL_W-1:0] line_id = '0;
  logic [LEN_W-1:0]  line_len = '0;
  logic [CELL_W-1:0] base = '0;
  logic [CELL_W-1:0] stride = '0;
  logic              busy, done, infeasible;
  logic [15:0]       option_count;

  line_option_gen_if bus();

  line_option_gen dut (
    .clk_100mhz   (clk_100mhz),
    .rst          (rst),
    .start        (start),
    .line_id      (line_id),
    .line_len     (line_len),
    .base         (base),
    .stride       (stride),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .infeasible   (infeasible),
    .option_count (option_count)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  logic [WORD_W-1:0] exp_q [$];

  // 0: ready low, 1: ready high, 2: random backpressure
  int   rdy_mode = 0;
  logic rnd = 1'b0;
  always @(posedge clk_100mhz) rnd <= 1'($urandom_range(0, 1));
  assign bus.out_ready = (rdy_mode == 1) || (rdy_mode == 2 && rnd);

  localparam logic [12:0] T1_W [18] = '{
    13'h0003, 13'h100A, 13'h100B, 13'h000C, 13'h100D, 13'h000E,
    13'h0003, 13'h100A, 13'h100B, 13'h000C, 13'h000D, 13'h100E,
    13'h0003, 13'h000A, 13'h100B, 13'h100C, 13'h000D, 13'h100E};
  localparam logic [12:0] T2_W [4] = '{13'h0007, 13'h1002, 13'h1007, 13'h100C};
  localparam logic [12:0] T4_W [5] = '{13'h0001, 13'h0000, 13'h0001, 13'h0002, 13'h0003};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor plus stall-stability checks.
  logic              stall = 1'b0;
  logic [WORD_W-1:0] stall_word = '0;
  always @(negedge clk_100mhz) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_word", 32'(bus.out_word), 32'(stall_word));
      end
      if (bus.out_valid && bus.out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", bus.out_word);
        end else begin
          check("out_word", 32'(bus.out_word), 32'(exp_q.pop_front()));
        end
      end
      stall      = bus.out_valid && !bus.out_ready;
      stall_word = bus.out_word;
    end
  end

  task automatic start_line(input logic [11:0] id, input logic [5:0] len,
                            input logic [11:0] b, input logic [11:0] s);
    line_id = id; line_len = len; base = b; stride = s;
    start = 1'b1;
    @(posedge clk_100mhz); #1;
    start = 1'b0;
  endtask

  task automatic send_clue(input logic [5:0] v, input logic last);
    logic ok;
    ok = 1'b0;
    bus.clue = v; bus.clue_last = last; bus.clue_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_100mhz);
      ok = bus.clue_ready;
      @(posedge clk_100mhz); #1;
      if (ok) break;
    end
    if (!ok) check("clue_timeout", 32'd0, 32'd1);
    bus.clue_valid = 1'b0; bus.clue_last = 1'b0;
  endtask

  task automatic wait_done(input int exp_cnt, input logic exp_inf);
    int   seen;
    logic fin;
    seen = 0; fin = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_100mhz);
      if (done) seen++;
      if (seen > 0 && !busy) begin fin = 1'b1; break; end
    end
    check("done_reached", 32'(fin), 32'd1);
    check("done_pulses", 32'(seen), 32'd1);
    check("option_count", 32'(option_count), 32'(exp_cnt));
    check("infeasible", 32'(infeasible), 32'(exp_inf));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk_100mhz); #1;
  endtask

  task automatic push_t1();
    for (int i = 0; i < 18; i++) exp_q.push_back(T1_W[i]);
  endtask

  task automatic run_t2();
    for (int i = 0; i < 4; i++) exp_q.push_back(T2_W[i]);
    start_line(12'd7, 6'd3, 12'd2, 12'd5);
    send_clue(6'd3, 1'b1);
    wait_done(1, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
    check({tag, "_clue_ready"}, 32'(bus.clue_ready), 32'd0);
    check({tag, "_busy"},       32'(busy),           32'd0);
    check({tag, "_done"},       32'(done),           32'd0);
    check({tag, "_infeasible"}, 32'(infeasible),     32'd0);
    check({tag, "_count"},      32'(option_count),   32'd0);
    check({tag, "_out_word"},   32'(bus.out_word),   32'd0);
  endtask

  initial begin
    int n;
    int target;
    bus.clue_valid = 1'b0; bus.clue = '0; bus.clue_last = 1'b0;
    repeat (3) @(posedge clk_100mhz);
    #1;
    check_reset_state("rst");
    rst = 1'b0;
    rdy_mode = 1;
    @(posedge clk_100mhz); #1;

    // len 5, {2,1}: three options, latency 1+2K, start while busy ignored
    push_t1();
    start_line(12'd3, 6'd5, 12'd10, 12'd1);
    send_clue(6'd2, 1'b0);
    send_clue(6'd1, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 200) begin @(posedge clk_100mhz); #1; n++; end
    check("first_valid_latency", 32'(n), 32'd5);
    line_id = 12'd99; start = 1'b1;
    @(posedge clk_100mhz); #1;
    start = 1'b0;
    wait_done(3, 1'b0);

    // len 3, single full-length clue, stride 5
    run_t2();

    // len 4, {2,2}: cannot fit
    start_line(12'd5, 6'd4, 12'd0, 12'd1);
    send_clue(6'd2, 1'b0);
    send_clue(6'd2, 1'b1);
    wait_done(0, 1'b1);

    // len 4, clue 0 only; a clue offered together with start must be ignored
    for (int i = 0; i < 5; i++) exp_q.push_back(T4_W[i]);
    bus.clue = 6'd3; bus.clue_last = 1'b1; bus.clue_valid = 1'b1;
    start_line(12'd1, 6'd4, 12'd0, 12'd1);
    check("clue_ready_after_start", 32'(bus.clue_ready), 32'd1);
    send_clue(6'd0, 1'b1);
    wait_done(1, 1'b0);

    // {2,1} again under random backpressure
    rdy_mode = 2;
    push_t1();
    start_line(12'd3, 6'd5, 12'd10, 12'd1);
    send_clue(6'd2, 1'b0);
    send_clue(6'd1, 1'b1);
    wait_done(3, 1'b0);
    rdy_mode = 1;

    // reset during the second option's cells, then a fresh line
    push_t1();
    target = n_pop + 8;
    start_line(12'd3, 6'd5, 12'd10, 12'd1);
    send_clue(6'd2, 1'b0);
    send_clue(6'd1, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_100mhz); #1;
      if (n_pop >= target) break;
    end
    check("reached_second_option", 32'(n_pop >= target), 32'd1);
    @(posedge clk_100mhz); #1;
    rst = 1'b1; rdy_mode = 0;
    @(posedge clk_100mhz); #1;
    check_reset_state("midrst");
    rst = 1'b0;
    exp_q.delete();
    rdy_mode = 1;
    @(posedge clk_100mhz); #1;
    run_t2();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/line_option_gen.md
# line_option_gen

Upstream feeder for `solver`. For one nonogram line, it takes the line length, cell-index mapping and clue list. It enumerates every legal placement of the clue blocks in lexicographic order of block start positions. Each placement is emitted as a 13-bit word stream in the format `solver` consumes: one header word, then one word per cell. The output goes to the BRAM writer that backs `solver`'s `bram_read`.

## Interface
- `MAX_LEN`, 32: maximum line length in cells.
- `MAX_CLUES`, 16: maximum clues per line.
- `clk_100mhz` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: latches `line_id`, `line_len`, `base`, `stride`; honoured only in IDLE.
- `line_id` input 12: line identifier, 1..m+n; emitted in the header.
- `line_len` input $clog2(MAX_LEN+1): cells in the line, 1..MAX_LEN.
- `base` input 12: global index of cell 0.
- `stride` input 12: global index step per cell (1 for rows, m for columns).
- `clue_valid` input 1, `clue_ready` output 1: clue handshake.
- `clue` input $clog2(MAX_LEN+1): clue value.
- `clue_last` input 1: marks the final clue.
- `out_word` output 13: header `{1'b0,line_id}` or cell `{value,cell_index}`.
- `out_valid` output 1, `out_ready` input 1: output handshake.
- `busy` output 1: high outside IDLE.
- `done` output 1: one-cycle pulse at end of line.
- `infeasible` output 1: clues cannot fit; held until the next accepted `start`.
- `option_count` output 16: options emitted for the current line; saturates at 16'hFFFF.

## Operation
- States: IDLE, LOAD, CHECK, PACK, BUILD, EMIT_HDR, EMIT_CELLS, ADVANCE, REPACK, DONE.
- IDLE → LOAD on `start`. `start` clears `option_count` and `infeasible`.
- LOAD: `clue_ready`=1. Each handshake with `clue`≠0 appends the clue; K = count. Zero clues are dropped. A handshake with `clue_last` → CHECK.
  - More than MAX_CLUES nonzero clues sets an internal overflow flag; the extras are discarded.
- CHECK: if overflow, or sum(clue)+K−1 > `line_len` → `infeasible`=1, go to DONE.
- PACK, one clue per cycle: start[0]=0; start[j]=start[j−1]+clue[j−1]+1. The bitmap is cleared on entry.
- BUILD, one clue per cycle: set bitmap bits start[k]..start[k]+clue[k]−1.
- K=0: PACK and BUILD are skipped. The line produces exactly one option, all zeros.
- EMIT_HDR: present header. On handshake → EMIT_CELLS, with cell counter c=0 and idx=`base`.
- EMIT_CELLS: present `{bitmap[c], idx}`.
  - On handshake: c+=1, idx+=`stride` (12-bit, wraps mod 4096).
  - After cell `line_len`−1: `option_count`+=1 (saturating), go to ADVANCE.
- ADVANCE: scan k from K−1 down to 0, one per cycle.
  - Block k is movable if start[k]+clue[k] < `line_len` (k=K−1), or start[k]+clue[k]+1 < start[k+1] (otherwise).
  - First movable k: start[k]+=1, go to REPACK.
  - None movable, or K=0 → DONE.
- REPACK: for j=k+1..K−1, one per cycle, start[j]=start[j−1]+clue[j−1]+1; then → BUILD.
- DONE: `done`=1 for one cycle, then → IDLE.

## Timing
- Reset: state IDLE. `out_valid`, `clue_ready`, `busy`, `done`, `infeasible`=0. `option_count`=0. `out_word`=0.
- Reset mid-operation abandons the line at that edge; no further words are emitted.
- `start` while `busy` is ignored.
- A word transfers on a clock edge with `out_valid`&&`out_ready`.
  - While `out_valid`&&!`out_ready`, `out_word` is held stable.
  - `out_valid` never drops without a transfer.
- Full throughput: once streaming, one word per cycle within an option.
- First `out_valid` is 1+2K cycles after the `clue_last` handshake edge (K=0: 1 cycle).
- Inter-option gap is at most 2K+K cycles (ADVANCE+REPACK+BUILD).
- `done` asserts one cycle after the last cell handshake of the last option plus the ADVANCE scan (up to K cycles); for an infeasible line, one cycle after CHECK.
- Simultaneous `start` and `clue_valid` in IDLE: the clue is not accepted (`clue_ready`=0).

## Structure
- `nonogram_pkg` holds:
  - constants `MAX_LEN`, `MAX_CLUES`, `WORD_W`=13, `CELL_W`=12;
  - the state enum;
  - helper functions `mk_header(id)` and `mk_cell(v,idx)`, shared with `solver`.
- Single module; no sub-module. The start/clue arrays are register files indexed by a per-state counter.

## Test plan
- len 5, clues {2,1}, id 3, base 10, stride 1 → 3 options (18 words):
  - 0x0003,0x100A,0x100B,0x000C,0x100D,0x000E;
  - then cells 11001;
  - then 01101;
  - `option_count`=3, one `done` pulse.
- len 3, clue {3}, id 7, base 2, stride 5 → 0x0007,0x1002,0x1007,0x100C; count 1.
- len 4, clues {2,2} → no `out_valid`, `infeasible`=1, `done` pulse, count 0.
- len 4, single clue 0 with `clue_last` → 0x0001 header (id 1), then 0x0000..0x0003 all value 0; count 1.
- Backpressure: {2,1} case with random `out_ready` → identical 18-word sequence, `out_word` stable while stalled.
- `rst` pulsed during the 2nd option's EMIT_CELLS → outputs at reset values next cycle. A subsequent new line runs normally.
